// File: rtl/clock_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_meter_pkg
// Purpose  : Shared types and default constants for the clock meter.
// Revision : 1.0 - initial release
// ============================================================================
package clock_meter_pkg;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_TIMEOUT     = 65535;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clock_meter_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Multi-flop synchronizer for an asynchronous input followed by a
//            registered rise/fall detector. rise/fall and q are aligned and
//            appear STAGES+1 clocks after the input changes.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;
  logic              rise_r;
  logic              fall_r;
  // Arming shift register: edges are suppressed until the chain holds real
  // input samples, so a reset-zeroed chain never reports a fake rise when
  // the input is already high.
  logic [STAGES:0]   arm;

  // Synchronizer chain, edge flop and registered edge strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      prev   <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      arm    <= '0;
    end else begin
      sync   <= {sync[STAGES-2:0], d};
      prev   <= sync[STAGES-1];
      arm    <= {arm[STAGES-1:0], 1'b1};
      rise_r <= arm[STAGES] &  sync[STAGES-1] & ~prev;
      fall_r <= arm[STAGES] & ~sync[STAGES-1] &  prev;
    end
  end

  assign q    = prev;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule
`default_nettype wire

// File: rtl/clock_meter.sv
`default_nettype none
// ============================================================================
// Module   : clock_meter
// Purpose  : Measures period and high time of an asynchronous square wave in
//            clk cycles, hands results out over valid/ready, and flags loss
//            of the measured clock and dropped measurements.
// Revision : 1.0 - initial release
// ============================================================================
module clock_meter
  import clock_meter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sense_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             lost_o,
  output logic             overrun_o,
  input  logic             clear_i
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TMO     = WIDTH'(TIMEOUT);

  state_t           state, state_n;
  logic [WIDTH-1:0] period_cnt, period_n;
  logic [WIDTH-1:0] high_cnt, high_n;
  logic             capture;
  logic             lost_set;
  logic             sense_q;
  logic             rise;
  logic             fall;

  // Counters stick at all-ones rather than wrapping
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (sense_i),
    .q    (sense_q),
    .rise (rise),
    .fall (fall)
  );

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      state      <= state_n;
      period_cnt <= period_n;
      high_cnt   <= high_n;
    end
  end

  // Next-state, counter update, capture and loss detection
  always_comb begin
    state_n  = state;
    period_n = period_cnt;
    high_n   = high_cnt;
    capture  = 1'b0;
    lost_set = 1'b0;
    if (!enable) begin
      state_n  = IDLE;
      period_n = '0;
      high_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n  = SEEK;
          period_n = '0;
          high_n   = '0;
        end
        SEEK: begin
          // period_cnt doubles as the wait counter; the partial first
          // period is never measured.
          if (rise) begin
            state_n  = HIGH;
            period_n = CNT_ONE;
            high_n   = CNT_ONE;
          end else if (period_cnt >= TMO - 1'b1) begin
            lost_set = 1'b1;
            period_n = '0;
          end else begin
            period_n = sat_inc(period_cnt);
          end
        end
        HIGH: begin
          if (period_cnt >= TMO) begin
            lost_set = 1'b1;
            state_n  = SEEK;
            period_n = '0;
            high_n   = '0;
          end else begin
            period_n = sat_inc(period_cnt);
            if (fall) begin
              state_n = LOW;
            end else if (sense_q) begin
              high_n = sat_inc(high_cnt);
            end
          end
        end
        LOW: begin
          if (period_cnt >= TMO) begin
            lost_set = 1'b1;
            state_n  = SEEK;
            period_n = '0;
            high_n   = '0;
          end else if (rise) begin
            capture  = 1'b1;
            state_n  = HIGH;
            period_n = CNT_ONE;
            high_n   = CNT_ONE;
          end else begin
            period_n = sat_inc(period_cnt);
          end
        end
        default: begin
          state_n  = IDLE;
          period_n = '0;
          high_n   = '0;
        end
      endcase
    end
  end

  // Result handshake and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      lost_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (capture) begin
        period_o <= period_cnt;
        high_o   <= high_cnt;
        valid_o  <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      // A capture that coincides with a transfer is not an overrun
      if (capture && valid_o && !ready_i) begin
        overrun_o <= 1'b1;
      end else if (clear_i) begin
        overrun_o <= 1'b0;
      end

      if (lost_set) begin
        lost_o <= 1'b1;
      end else if (clear_i) begin
        lost_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_meter
// Purpose  : Directed self-checking bench for clock_meter. One instance uses
//            WIDTH=16/TIMEOUT=100; a second uses WIDTH=8/TIMEOUT=255 with a
//            300-cycle input period that must always be flagged as lost.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_meter;
  import clock_meter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sense;
  logic        ready;
  logic        clear;
  logic [15:0] period;
  logic [15:0] high;
  logic        valid;
  logic        lost;
  logic        overrun;

  logic        en8;
  logic        sense8;
  logic        ready8;
  logic        clear8;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        valid8;
  logic        lost8;
  logic        overrun8;

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus generator controls (written only by the main sequence)
  int gen_per  = 10;
  int gen_hi   = 5;
  bit gen_mode = 1'b0;
  bit hold_val = 1'b0;
  int gen_ph   = 0;
  int ph8      = 0;
  bit valid8_seen = 1'b0;

  always #5 clk = ~clk;

  clock_meter #(
    .WIDTH       (16),
    .TIMEOUT     (100),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sense_i   (sense),
    .period_o  (period),
    .high_o    (high),
    .valid_o   (valid),
    .ready_i   (ready),
    .lost_o    (lost),
    .overrun_o (overrun),
    .clear_i   (clear)
  );

  clock_meter #(
    .WIDTH       (8),
    .TIMEOUT     (255),
    .SYNC_STAGES (2)
  ) dut8 (
    .clk       (clk),
    .rst       (rst),
    .enable    (en8),
    .sense_i   (sense8),
    .period_o  (period8),
    .high_o    (high8),
    .valid_o   (valid8),
    .ready_i   (ready8),
    .lost_o    (lost8),
    .overrun_o (overrun8),
    .clear_i   (clear8)
  );

  // Main square wave, changing off the clock edge to mimic an async source
  initial begin
    sense = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gen_mode) begin
        sense  = (gen_ph < gen_hi);
        gen_ph = (gen_ph + 1 >= gen_per) ? 0 : gen_ph + 1;
      end else begin
        sense = hold_val;
      end
    end
  end

  // Slow 300-cycle square wave for the 8-bit instance
  initial begin
    sense8 = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      sense8 = (ph8 < 150);
      ph8    = (ph8 == 299) ? 0 : ph8 + 1;
    end
  end

  always @(negedge clk) begin
    if (valid8 === 1'b1) valid8_seen <= 1'b1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; ready = 1'b1; clear = 1'b0;
    en8 = 1'b1; ready8 = 1'b1; clear8 = 1'b0;
    gen_mode = 1'b0; hold_val = 1'b0;
    wait_cycles(3);
    vectors++; if (period !== 16'd0) begin miscompares++; $display("FAIL reset_period: got %0d expected 0", period); end
    vectors++; if (high !== 16'd0) begin miscompares++; $display("FAIL reset_high: got %0d expected 0", high); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid); end
    vectors++; if (lost !== 1'b0) begin miscompares++; $display("FAIL reset_lost: got %b expected 0", lost); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
    rst = 1'b0;
  endtask

  task automatic measure(input string name, input int cycles, input int exp_pulses,
                         input int exp_per, input int exp_hi);
    int pulses;
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        pulses++;
        vectors++; if (period !== exp_per[15:0]) begin miscompares++; $display("FAIL %s_period: got %0d expected %0d", name, period, exp_per); end
        vectors++; if (high !== exp_hi[15:0]) begin miscompares++; $display("FAIL %s_high: got %0d expected %0d", name, high, exp_hi); end
      end
    end
    vectors++; if (pulses != exp_pulses) begin miscompares++; $display("FAIL %s_pulses: got %0d expected %0d", name, pulses, exp_pulses); end
  endtask

  task automatic test_basic();
    gen_per = 10; gen_hi = 5; gen_mode = 1'b1; enable = 1'b1; ready = 1'b1;
    wait_cycles(60);
    measure("basic", 40, 4, 10, 5);
  endtask

  task automatic test_duty();
    gen_per = 40; gen_hi = 10;
    wait_cycles(100);
    measure("duty25", 80, 2, 40, 10);
  endtask

  task automatic test_overrun();
    gen_per = 10; gen_hi = 5;
    wait_cycles(60);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_idle: got %b expected 0", overrun); end
    ready = 1'b0;
    wait_cycles(35);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid_held: got %b expected 1", valid); end
    vectors++; if (period !== 16'd10) begin miscompares++; $display("FAIL ovr_period: got %0d expected 10", period); end
    vectors++; if (high !== 16'd5) begin miscompares++; $display("FAIL ovr_high: got %0d expected 5", high); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    ready = 1'b1;
    wait_cycles(1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_enable();
    ready = 1'b0;
    wait_cycles(15);
    enable = 1'b0;
    wait_cycles(20);
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL en_state: got %0d expected %0d", dut.state, IDLE); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL en_valid_kept: got %b expected 1", valid); end
    vectors++; if (period !== 16'd10) begin miscompares++; $display("FAIL en_period_kept: got %0d expected 10", period); end
    enable = 1'b1; ready = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic count_to_valid(input string name, input int bound);
    int  cnt;
    int  rises;
    logic prev;
    cnt = 0; rises = 0; prev = sense;
    while (valid !== 1'b1 && cnt < bound) begin
      @(negedge clk);
      cnt++;
      if (sense && !prev) rises++;
      prev = sense;
    end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid: got %b expected 1 within %0d cycles", name, valid, bound); end
    vectors++; if (rises != 2) begin miscompares++; $display("FAIL %s_rises: got %0d expected 2", name, rises); end
    vectors++; if (period !== 16'd10) begin miscompares++; $display("FAIL %s_period: got %0d expected 10", name, period); end
    vectors++; if (high !== 16'd5) begin miscompares++; $display("FAIL %s_high: got %0d expected 5", name, high); end
  endtask

  task automatic test_loss();
    int cnt;
    wait_cycles(30);
    vectors++; if (lost !== 1'b0) begin miscompares++; $display("FAIL loss_idle: got %b expected 0", lost); end
    hold_val = 1'b1; gen_mode = 1'b0;
    cnt = 0;
    while (lost !== 1'b1 && cnt < 150) begin
      @(negedge clk);
      cnt++;
    end
    vectors++; if (lost !== 1'b1) begin miscompares++; $display("FAIL loss_set: got %b expected 1", lost); end
    vectors++; if (cnt < 90 || cnt > 115) begin miscompares++; $display("FAIL loss_latency: got %0d expected 90..115", cnt); end
    vectors++; if (dut.state !== SEEK) begin miscompares++; $display("FAIL loss_state: got %0d expected %0d", dut.state, SEEK); end
    clear = 1'b1; gen_mode = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vectors++; if (lost !== 1'b0) begin miscompares++; $display("FAIL loss_clear: got %b expected 0", lost); end
    count_to_valid("resume", 60);
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    while (dut.state !== HIGH && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    vectors++; if (dut.state !== HIGH) begin miscompares++; $display("FAIL rmid_in_high: got %0d expected %0d", dut.state, HIGH); end
    rst = 1'b1;
    #1;
    vectors++; if (period !== 16'd0) begin miscompares++; $display("FAIL rmid_period: got %0d expected 0", period); end
    vectors++; if (high !== 16'd0) begin miscompares++; $display("FAIL rmid_high: got %0d expected 0", high); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b expected 0", valid); end
    vectors++; if (lost !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL rmid_flags: got %b%b expected 00", lost, overrun); end
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL rmid_state: got %0d expected %0d", dut.state, IDLE); end
    @(negedge clk);
    rst = 1'b0;
    count_to_valid("rmid", 50);
  endtask

  task automatic test_wide();
    wait_cycles(700);
    vectors++; if (lost8 !== 1'b1) begin miscompares++; $display("FAIL wide_lost: got %b expected 1", lost8); end
    vectors++; if (valid8_seen !== 1'b0) begin miscompares++; $display("FAIL wide_no_capture: got %b expected 0", valid8_seen); end
    vectors++; if (period8 !== 8'd0 || high8 !== 8'd0) begin miscompares++; $display("FAIL wide_data: got %0d/%0d expected 0/0", period8, high8); end
    vectors++; if (overrun8 !== 1'b0) begin miscompares++; $display("FAIL wide_overrun: got %b expected 0", overrun8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty();
    test_overrun();
    test_enable();
    test_loss();
    test_reset_mid();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/clock_meter.md
CLOCK_METER -- requirements
Module: clock_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of all cycle counts.
REQ-002 SHALL have parameter TIMEOUT, default 65535, clk cycles without an edge before loss is declared; legal range 2..2**WIDTH-1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops on sense_i; minimum 2.
REQ-004 SHALL have port clk input 1, sole clock.
REQ-005 SHALL have port rst input 1, asynchronous, active-high reset.
REQ-006 SHALL have port enable input 1, measurement enable, synchronous to clk.
REQ-007 SHALL have port sense_i input 1, asynchronous measured clock or square wave.
REQ-008 SHALL have port period_o output WIDTH, clk cycles between consecutive rising edges.
REQ-009 SHALL have port high_o output WIDTH, clk cycles sense was high within that period.
REQ-010 SHALL have port valid_o output 1, measurement available.
REQ-011 SHALL have port ready_i input 1, consumer accepts measurement.
REQ-012 SHALL have port lost_o output 1, sticky loss-of-clock flag.
REQ-013 SHALL have port overrun_o output 1, sticky flag for measurement dropped while valid_o held.
REQ-014 SHALL have port clear_i input 1, synchronous clear of lost_o and overrun_o.

Function
REQ-015 SHALL pass sense_i through SYNC_STAGES flops plus one edge-detect flop; rise/fall seen SYNC_STAGES+1 cycles after sense_i changes.
REQ-016 SHALL implement FSM states IDLE, SEEK, HIGH, LOW.
REQ-017 IDLE: enable=0; counters held at 0; enable=1 -> SEEK next cycle.
REQ-018 SEEK: wait for synchronized rise -> HIGH with high and period counters loaded to 1; discard partial first period.
REQ-019 HIGH: both counters increment each cycle; fall -> LOW.
REQ-020 LOW: period counter increments; rise -> capture period and high counts, reload both counters to 1, stay measuring in HIGH.
REQ-021 Capture SHALL update period_o/high_o and assert valid_o on the cycle after the rise cycle.
REQ-022 valid_o/ready_i SHALL follow valid-ready: transfer when both high; valid_o and data stable until transfer.
REQ-023 Capture while valid_o=1 and ready_i=0 SHALL overwrite data, keep valid_o=1, set overrun_o.
REQ-024 Capture on the same cycle as a transfer SHALL load new data with valid_o=1 and no overrun.
REQ-025 Counters SHALL saturate at 2**WIDTH-1, never wrap.
REQ-026 Period counter reaching TIMEOUT in HIGH or LOW, or SEEK waiting TIMEOUT cycles, SHALL set lost_o and enter SEEK; no capture.
REQ-027 enable deasserted in any state SHALL return to IDLE next cycle; pending valid_o and data retained.
REQ-028 clear_i SHALL clear lost_o and overrun_o next cycle; a simultaneous set event wins.
REQ-029 Rise and fall detected on the same cycle SHALL be impossible by construction; glitches shorter than one clk are not required to be measured.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, synchronizer and edge flops 0, counters 0, period_o 0, high_o 0, valid_o 0, lost_o 0, overrun_o 0.
REQ-031 Reset deassertion mid-period SHALL restart measurement via SEEK; no partial capture.

Structure
REQ-032 Package clock_meter_pkg SHALL hold the state enum typedef and default WIDTH/TIMEOUT constants.
REQ-033 Synchronizer plus edge detector SHALL be sub-module sync_edge (ports clk, rst, d, q, rise, fall).
REQ-034 No latches, single always_ff domain on clk with asynchronous rst.

Verification
REQ-035 clk 100 MHz, sense_i 10 MHz 50% duty, enable=1, ready_i=1 -> steady period_o=10, high_o=5, one valid pulse per 10 cycles after first full period.
REQ-036 sense_i 25% duty, period 40 cycles -> period_o=40, high_o=10.
REQ-037 ready_i=0 for three sense periods -> valid_o held, data equals latest capture, overrun_o=1; clear_i pulse -> overrun_o=0.
REQ-038 TIMEOUT=100, sense_i stopped high -> lost_o=1 within 100 cycles of last edge, state SEEK; sense resumes -> valid captures resume after one discarded period.
REQ-039 WIDTH=8, TIMEOUT=255, sense period 300 cycles -> lost_o=1, period_o never wraps to small value.
REQ-040 rst asserted mid-HIGH, released -> all outputs 0 immediately on assertion; first capture only after two subsequent rises.
